alu_exec: RTL
=============

Name: alu_exec

Overview:
- Single-issue integer execution unit directly downstream of the reservation station.
- Accepts one dispatched RV32I non-memory operation per cycle and computes result, branch outcome and target PC.
- Registers the result onto the ALU result bus, which the RS, SLB and ROB snoop next cycle.
- Fixed 1-cycle latency, never stalls: RS may dispatch every cycle.

Parameters:
- OP_W, `OP_SIZE_LOG, width of op_type encoding (shared `OP_* defines)
- ROB_W, `ROB_SIZE_LOG, width of ROB index

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; low = freeze all state
- pred_fail_flag  in  1  misprediction flush from ROB
- ALU_enable  in  1  dispatch valid from RS
- op_to_ALU  in  OP_W  operation
- vj_to_ALU  in  32  rs1 value
- vk_to_ALU  in  32  rs2 value
- imm_to_ALU  in  32  sign/zero-extended immediate as produced by decoder
- robid_to_ALU  in  ROB_W  destination ROB entry
- curpc_to_ALU  in  32  instruction PC
- ALU_valid  out  1  result broadcast valid (one cycle per op)
- ALU_value  out  32  rd value (branches: taken flag in bit 0)
- ALU_robid  out  ROB_W  ROB entry of result
- ALU_jump  out  1  control transfer taken (JAL/JALR always 1, branches = taken, else 0)
- ALU_target_pc  out  32  actual next PC for control ops; pc+4 otherwise

Behaviour:
- Reset (rst=1 at clk edge): ALU_valid=0, ALU_value=0, ALU_robid=0, ALU_jump=0, ALU_target_pc=0.
- Priority per edge: rst, then pred_fail_flag, then !rdy, then normal operation.
- pred_fail_flag=1: ALU_valid<=0; the op presented that cycle is dropped; other outputs hold. Same-cycle dispatch is discarded.
- rdy=0: all outputs hold their values, including ALU_valid. The RS is frozen too, so a held valid is not double-counted downstream.
- Normal: ALU_valid<=ALU_enable. When ALU_enable=1, value/robid/jump/target are registered from the combinational compute. When ALU_enable=0, the data outputs hold.
- Latency: operands sampled at edge N, result visible after edge N, consumed at edge N+1.
- Compute, all 32-bit modulo 2^32:
  - LUI: value=imm.
  - AUIPC: value=pc+imm.
  - JAL: value=pc+4, target=pc+imm.
  - JALR: value=pc+4, target=(vj+imm)&~1.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU: signed or unsigned compare of vj,vk. value={31'b0,taken}. target=taken?pc+imm:pc+4.
  - ADD/SUB/XOR/OR/AND/SLT/SLTU: vj op vk.
  - ADDI/XORI/ORI/ANDI/SLTI/SLTIU: vj op imm. SLTIU compares vj against imm as unsigned.
  - SLL/SRL/SRA: shift amount = vk[4:0]. SLLI/SRLI/SRAI: shift amount = imm[4:0]. SRA/SRAI are arithmetic.
- Non-control ops: jump=0, target=pc+4.
- Undefined op codes: value=0, jump=0, target=pc+4, ALU_valid still asserted so the ROB entry retires.
- Load/store op codes are never dispatched here. If received, they are treated as undefined.
- Back-to-back dispatch: a new result every cycle; no internal buffering.

Optional Feature:
- Macro ALU_STATS_EN.
- When defined, adds outputs stat_branch_cnt (32), stat_taken_cnt (32) and stat_jump_cnt (32).
- On each accepted conditional branch, stat_branch_cnt increments, and stat_taken_cnt increments as well if the branch is taken.
- On each accepted JAL/JALR, stat_jump_cnt increments.
- The counters are cleared only by rst, not by pred_fail_flag, and hold while rdy=0. They wrap at 2^32.
- Without the macro, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset then idle: all outputs 0, ALU_valid stays 0 for 10 cycles with ALU_enable=0.
- ADD vj=0x7FFFFFFF vk=1 robid=3 -> next cycle ALU_valid=1, value=0x80000000, robid=3, jump=0, target=pc+4; following cycle ALU_valid=0.
- Shift and compare ops:
  - SRAI vj=0x80000000 imm=4 -> value 0xF8000000.
  - SLTU vj=1 vk=0xFFFFFFFF -> value 1.
  - SLT with the same operands -> value 0.
- Control ops:
  - BLT vj=-1 vk=0 pc=0x100 imm=0x20 -> jump=1, target 0x120, value 1.
  - BGEU with the same operands -> jump=1, target 0x120 (0xFFFFFFFF >= 0 unsigned).
  - JALR vj=0x1003 imm=0 pc=0x40 -> value 0x44, target 0x1002.
- Stall and flush:
  - ALU_enable=1 with rdy=0 for 3 cycles -> outputs frozen; the op is taken on the first rdy=1 edge.
  - pred_fail_flag together with ALU_enable -> ALU_valid=0 next cycle.
- With ALU_STATS_EN: 3 branches (2 taken) plus 1 JAL -> counts 3/2/1. A flush does not clear them; rst does.

Source files
------------

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - single-cycle RV32I integer execution unit feeding the ALU result bus.
// Optional branch/jump statistics counters are built when ALU_STATS_EN is defined.

`ifndef OP_SIZE_LOG
`define OP_SIZE_LOG 6
`endif
`ifndef ROB_SIZE_LOG
`define ROB_SIZE_LOG 4
`endif

`ifndef OP_LUI
`define OP_LUI   1
`define OP_AUIPC 2
`define OP_JAL   3
`define OP_JALR  4
`define OP_BEQ   5
`define OP_BNE   6
`define OP_BLT   7
`define OP_BGE   8
`define OP_BLTU  9
`define OP_BGEU  10
`define OP_LB    11
`define OP_LH    12
`define OP_LW    13
`define OP_LBU   14
`define OP_LHU   15
`define OP_SB    16
`define OP_SH    17
`define OP_SW    18
`define OP_ADDI  19
`define OP_SLTI  20
`define OP_SLTIU 21
`define OP_XORI  22
`define OP_ORI   23
`define OP_ANDI  24
`define OP_SLLI  25
`define OP_SRLI  26
`define OP_SRAI  27
`define OP_ADD   28
`define OP_SUB   29
`define OP_SLL   30
`define OP_SLT   31
`define OP_SLTU  32
`define OP_XOR   33
`define OP_SRL   34
`define OP_SRA   35
`define OP_OR    36
`define OP_AND   37
`endif

module alu_exec #(
   parameter int OP_W  = `OP_SIZE_LOG,
   parameter int ROB_W = `ROB_SIZE_LOG
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             pred_fail_flag,
   input  logic             ALU_enable,
   input  logic [OP_W-1:0]  op_to_ALU,
   input  logic [31:0]      vj_to_ALU,
   input  logic [31:0]      vk_to_ALU,
   input  logic [31:0]      imm_to_ALU,
   input  logic [ROB_W-1:0] robid_to_ALU,
   input  logic [31:0]      curpc_to_ALU,
`ifdef ALU_STATS_EN
   output logic [31:0]      stat_branch_cnt,
   output logic [31:0]      stat_taken_cnt,
   output logic [31:0]      stat_jump_cnt,
`endif
   output logic             ALU_valid,
   output logic [31:0]      ALU_value,
   output logic [ROB_W-1:0] ALU_robid,
   output logic             ALU_jump,
   output logic [31:0]      ALU_target_pc
);

   logic [31:0] vj, vk, imm, pc, pc4, pc_imm;
   logic [31:0] c_value, c_target;
   logic        c_jump, c_is_branch, c_is_jal;
   logic        taken;

   assign vj     = vj_to_ALU;
   assign vk     = vk_to_ALU;
   assign imm    = imm_to_ALU;
   assign pc     = curpc_to_ALU;
   assign pc4    = pc + 32'd4;
   assign pc_imm = pc + imm;

   always_comb begin
      c_value     = 32'd0;
      c_jump      = 1'b0;
      c_target    = pc4;
      c_is_branch = 1'b0;
      c_is_jal    = 1'b0;
      taken       = 1'b0;
      case (op_to_ALU)
         OP_W'(`OP_LUI):   c_value = imm;
         OP_W'(`OP_AUIPC): c_value = pc_imm;
         OP_W'(`OP_JAL): begin
            c_value  = pc4;
            c_target = pc_imm;
            c_jump   = 1'b1;
            c_is_jal = 1'b1;
         end
         OP_W'(`OP_JALR): begin
            c_value  = pc4;
            c_target = (vj + imm) & ~32'd1;
            c_jump   = 1'b1;
            c_is_jal = 1'b1;
         end
         OP_W'(`OP_BEQ), OP_W'(`OP_BNE), OP_W'(`OP_BLT),
         OP_W'(`OP_BGE), OP_W'(`OP_BLTU), OP_W'(`OP_BGEU): begin
            case (op_to_ALU)
               OP_W'(`OP_BEQ):  taken = (vj == vk);
               OP_W'(`OP_BNE):  taken = (vj != vk);
               OP_W'(`OP_BLT):  taken = ($signed(vj) <  $signed(vk));
               OP_W'(`OP_BGE):  taken = ($signed(vj) >= $signed(vk));
               OP_W'(`OP_BLTU): taken = (vj <  vk);
               default:         taken = (vj >= vk);
            endcase
            c_is_branch = 1'b1;
            c_value     = {31'd0, taken};
            c_jump      = taken;
            c_target    = taken ? pc_imm : pc4;
         end
         OP_W'(`OP_ADDI):  c_value = vj + imm;
         OP_W'(`OP_SLTI):  c_value = {31'd0, $signed(vj) < $signed(imm)};
         OP_W'(`OP_SLTIU): c_value = {31'd0, vj < imm};
         OP_W'(`OP_XORI):  c_value = vj ^ imm;
         OP_W'(`OP_ORI):   c_value = vj | imm;
         OP_W'(`OP_ANDI):  c_value = vj & imm;
         OP_W'(`OP_SLLI):  c_value = vj << imm[4:0];
         OP_W'(`OP_SRLI):  c_value = vj >> imm[4:0];
         OP_W'(`OP_SRAI):  c_value = $unsigned($signed(vj) >>> imm[4:0]);
         OP_W'(`OP_ADD):   c_value = vj + vk;
         OP_W'(`OP_SUB):   c_value = vj - vk;
         OP_W'(`OP_SLL):   c_value = vj << vk[4:0];
         OP_W'(`OP_SLT):   c_value = {31'd0, $signed(vj) < $signed(vk)};
         OP_W'(`OP_SLTU):  c_value = {31'd0, vj < vk};
         OP_W'(`OP_XOR):   c_value = vj ^ vk;
         OP_W'(`OP_SRL):   c_value = vj >> vk[4:0];
         OP_W'(`OP_SRA):   c_value = $unsigned($signed(vj) >>> vk[4:0]);
         OP_W'(`OP_OR):    c_value = vj | vk;
         OP_W'(`OP_AND):   c_value = vj & vk;
         // loads, stores and unknown codes still retire with a zero result
         default:          c_value = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ALU_valid     <= 1'b0;
         ALU_value     <= 32'd0;
         ALU_robid     <= '0;
         ALU_jump      <= 1'b0;
         ALU_target_pc <= 32'd0;
      end else if (pred_fail_flag) begin
         ALU_valid <= 1'b0;
      end else if (rdy) begin
         ALU_valid <= ALU_enable;
         if (ALU_enable) begin
            ALU_value     <= c_value;
            ALU_robid     <= robid_to_ALU;
            ALU_jump      <= c_jump;
            ALU_target_pc <= c_target;
         end
      end
   end

`ifdef ALU_STATS_EN
   logic accept;
   assign accept = ALU_enable && rdy && !pred_fail_flag;

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_branch_cnt <= 32'd0;
         stat_taken_cnt  <= 32'd0;
         stat_jump_cnt   <= 32'd0;
      end else if (accept) begin
         if (c_is_branch) stat_branch_cnt <= stat_branch_cnt + 32'd1;
         if (c_is_branch && taken) stat_taken_cnt <= stat_taken_cnt + 32'd1;
         if (c_is_jal) stat_jump_cnt <= stat_jump_cnt + 32'd1;
      end
   end
`endif

endmodule
